// File: rtl/eth_rx_mac.sv
// eth_rx_mac: nibble-wide Ethernet receive framer. It detects preamble/SFD, filters on the
// destination address, checks CRC-32 and length, strips the FCS and keeps frame statistics.
module eth_rx_mac #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_en,
  input  logic        rgmii_rx_ctl,
  input  logic [3:0]  rgmii_rxd,
  input  logic [47:0] mac_addr,
  input  logic        promisc_en,
  input  logic        bcast_en,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_last,
  output logic        rx_err,
  output logic [3:0]  rx_status,
  output logic [31:0] frame_ok_count,
  output logic [31:0] frame_err_count,
  output logic [31:0] drop_count
);

  localparam int               LEN_W       = $clog2(MAX_FRAME + 2);
  localparam logic [LEN_W-1:0] LEN_SAT     = LEN_W'(MAX_FRAME + 1);
  localparam logic [LEN_W-1:0] LEN_MIN     = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] LEN_ADDR    = LEN_W'(6);
  localparam logic [LEN_W-1:0] LEN_EMIT    = LEN_W'(7);
  localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DROP     = 3'd4
  } state_t;

  // Reflected CRC-32 (0xEDB88320), one byte, LSB first, no inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else                c = c >> 1;
    end
    return c;
  endfunction

  state_t           state_r, state_s;
  logic             phase_r, phase_s;
  logic [3:0]       lo_r, lo_s;
  logic [31:0]      crc_r, crc_s;
  logic [47:0]      dl_r, dl_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic             drain_r, drain_s;
  logic [3:0]       status_r, status_s;

  logic [7:0]       rx_data_r, data_s;
  logic             rx_valid_r, valid_s;
  logic             rx_last_r, last_s;
  logic             rx_err_r, err_s;
  logic [3:0]       rx_status_r, stat_out_s;
  logic             drop_inc_s;
  logic [31:0]      ok_cnt_r, err_cnt_r, drop_cnt_r;

  logic [7:0]       byte_s;
  logic [47:0]      dest_s;
  logic             addr_ok_s;
  logic [LEN_W-1:0] len_inc_s;

  // The delay line holds bytes L-5..L (oldest in the top byte), so the destination is
  // the delay line shifted by the byte completing right now.
  assign byte_s    = {rgmii_rxd, lo_r};
  assign dest_s    = {dl_r[39:0], byte_s};
  assign addr_ok_s = promisc_en || (dest_s == mac_addr) ||
                     (bcast_en && (dest_s == 48'hFFFF_FFFF_FFFF));
  assign len_inc_s = (len_r == LEN_SAT) ? len_r : len_r + LEN_W'(1);

  // Next-state, datapath and output-beat decode.
  always_comb begin
    state_s    = state_r;
    phase_s    = phase_r;
    lo_s       = lo_r;
    crc_s      = crc_r;
    dl_s       = dl_r;
    len_s      = len_r;
    drain_s    = drain_r;
    status_s   = status_r;
    data_s     = 8'h00;
    valid_s    = 1'b0;
    last_s     = 1'b0;
    err_s      = 1'b0;
    stat_out_s = 4'h0;
    drop_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rgmii_rx_ctl) begin
          if ((rgmii_rxd == 4'h5) && rx_en) state_s = ST_PREAMBLE;
          else                              state_s = ST_DROP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (!rgmii_rx_ctl) begin
          state_s = ST_IDLE;
        end else if (rgmii_rxd == 4'h5) begin
          state_s = ST_PREAMBLE;
        end else if (rgmii_rxd == 4'hD) begin
          state_s = ST_DATA;
          crc_s   = CRC_INIT;
          len_s   = '0;
          phase_s = 1'b0;
        end else begin
          state_s    = ST_DROP;
          drop_inc_s = 1'b1;
        end
      end
      ST_DATA: begin
        if (rgmii_rx_ctl) begin
          if (!phase_r) begin
            lo_s    = rgmii_rxd;
            phase_s = 1'b1;
          end else begin
            phase_s = 1'b0;
            crc_s   = crc32_byte(crc_r, byte_s);
            dl_s    = dest_s;
            len_s   = len_inc_s;
            if (len_inc_s == LEN_ADDR) begin
              if (!addr_ok_s) begin
                state_s    = ST_DROP;
                drop_inc_s = 1'b1;
              end else begin
                state_s = ST_DATA;
              end
            end else if (len_inc_s == LEN_SAT) begin
              // Oversize: terminate the frame with an empty error beat.
              valid_s    = 1'b1;
              last_s     = 1'b1;
              err_s      = 1'b1;
              stat_out_s = 4'b0100;
              state_s    = ST_DROP;
            end else if (len_inc_s >= LEN_EMIT) begin
              valid_s = 1'b1;
              data_s  = dl_r[47:40];
            end else begin
              state_s = ST_DATA;
            end
          end
        end else begin
          if (len_r < LEN_ADDR) begin
            state_s    = ST_IDLE;
            drop_inc_s = 1'b1;
          end else begin
            state_s  = ST_DRAIN;
            drain_s  = 1'b0;
            valid_s  = 1'b1;
            data_s   = dl_r[47:40];
            status_s = {phase_r, 1'b0, (len_r < LEN_MIN), (crc_r != CRC_RESIDUE)};
          end
        end
      end
      ST_DRAIN: begin
        if (!drain_r) begin
          drain_s    = 1'b1;
          valid_s    = 1'b1;
          last_s     = 1'b1;
          data_s     = dl_r[39:32];
          stat_out_s = status_r;
          err_s      = |status_r;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!rgmii_rx_ctl) state_s = ST_IDLE;
        else               state_s = ST_DROP;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      phase_r  <= 1'b0;
      lo_r     <= 4'h0;
      crc_r    <= CRC_INIT;
      dl_r     <= 48'h0;
      len_r    <= '0;
      drain_r  <= 1'b0;
      status_r <= 4'h0;
    end else begin
      state_r  <= state_s;
      phase_r  <= phase_s;
      lo_r     <= lo_s;
      crc_r    <= crc_s;
      dl_r     <= dl_s;
      len_r    <= len_s;
      drain_r  <= drain_s;
      status_r <= status_s;
    end
  end

  // Registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      rx_last_r   <= 1'b0;
      rx_err_r    <= 1'b0;
      rx_status_r <= 4'h0;
    end else begin
      rx_data_r   <= data_s;
      rx_valid_r  <= valid_s;
      rx_last_r   <= last_s;
      rx_err_r    <= err_s;
      rx_status_r <= stat_out_s;
    end
  end

  // Frame counters; ok/err follow the rx_last beat by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt_r   <= 32'd0;
      err_cnt_r  <= 32'd0;
      drop_cnt_r <= 32'd0;
    end else begin
      if (drop_inc_s)              drop_cnt_r <= drop_cnt_r + 32'd1;
      if (rx_last_r && !rx_err_r)  ok_cnt_r   <= ok_cnt_r + 32'd1;
      if (rx_last_r && rx_err_r)   err_cnt_r  <= err_cnt_r + 32'd1;
    end
  end

  assign rx_data         = rx_data_r;
  assign rx_valid        = rx_valid_r;
  assign rx_last         = rx_last_r;
  assign rx_err          = rx_err_r;
  assign rx_status       = rx_status_r;
  assign frame_ok_count  = ok_cnt_r;
  assign frame_err_count = err_cnt_r;
  assign drop_count      = drop_cnt_r;

endmodule

// File: doc/eth_rx_mac.md
# eth_rx_mac

Receive-side Ethernet MAC framer for the Gigabit Ethernet controller. It sits between the PHY-side nibble receive pins and the RX DMA/FIFO path. Per frame it:
- detects preamble/SFD;
- assembles bytes;
- filters on destination MAC;
- checks FCS (CRC-32) and length;
- strips the FCS and emits a byte stream with per-frame status and statistics counters.

## Interface
Parameters:
- MIN_FRAME, 64, minimum legal frame length in bytes, FCS included
- MAX_FRAME, 1518, maximum legal frame length in bytes, FCS included

Ports (single clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  core clock, 125 MHz; all inputs sampled on its rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_en  in  1  receiver enable; sampled only in IDLE
- rgmii_rx_ctl  in  1  receive data valid from PHY
- rgmii_rxd  in  4  receive nibble; low nibble of each byte first
- mac_addr  in  48  station address; first destination byte on wire = mac_addr[47:40]
- promisc_en  in  1  accept every destination address
- bcast_en  in  1  accept FF:FF:FF:FF:FF:FF
- rx_data  out  8  output byte
- rx_valid  out  1  rx_data valid, one-cycle beat; no backpressure
- rx_last  out  1  final beat of frame
- rx_err  out  1  with rx_last: frame bad, equals OR of rx_status
- rx_status  out  4  with rx_last: [0] crc_err, [1] runt, [2] too_long, [3] align_err
- frame_ok_count  out  32  frames ended with rx_err=0
- frame_err_count  out  32  frames ended with rx_err=1
- drop_count  out  32  frames discarded with no beat emitted

## Operation
- Reset values:
  - all outputs 0, counters 0;
  - state IDLE;
  - CRC register 0xFFFFFFFF.
- State IDLE:
  - rgmii_rx_ctl=1, nibble 0x5, rx_en=1 → PREAMBLE.
  - rgmii_rx_ctl=1 with any other nibble, or with rx_en=0 → DROP (no count).
- State PREAMBLE:
  - nibble 0x5 → stay.
  - 0xD → DATA; CRC register and byte count L reset.
  - any other nibble → DROP, drop_count+1.
  - rgmii_rx_ctl=0 → IDLE, no count.
- State DATA: nibble pairs form bytes (second nibble = bits [7:4]). Each completed byte:
  - enters the CRC, which uses the reflected polynomial 0xEDB88320, LSB first, init 0xFFFFFFFF, no final inversion;
  - shifts into a 6-byte delay line;
  - increments L, which saturates at MAX_FRAME+1.
- Address filter:
  - decided when byte 6 (L=6) completes;
  - accept if promisc_en, or destination==mac_addr, or (bcast_en and destination all-FF);
  - reject → DROP, drop_count+1, nothing emitted.
- Emission: when byte n completes with n≥7 (1-based), byte n-6 is emitted. The first emission therefore occurs strictly after the filter decision.
- End of frame: rgmii_rx_ctl=0 sampled in DATA → DRAIN.
  - DRAIN emits the two remaining payload bytes (L-5, L-4, 1-based) on consecutive cycles; the second carries rx_last.
  - The 4 FCS bytes are discarded.
  - L<6 at end → no output, drop_count+1.
  - L=6 (filter passed, no emission yet) → DRAIN behaves normally; the frame ends with runt.
- Status flags at rx_last:
  - crc_err: CRC register ≠ 0xDEBB20E3.
  - runt: L<MIN_FRAME.
  - align_err: rgmii_rx_ctl fell after a low nibble; the partial byte is discarded.
- Oversize:
  - When byte MAX_FRAME+1 completes, the normal emission that cycle is replaced by rx_last=1, rx_err=1, too_long=1, rx_data=0, with no payload byte.
  - frame_err_count+1, then → DROP.
- State DROP: wait for rgmii_rx_ctl=0, then → IDLE.
- DRAIN: rgmii_rxd/rgmii_rx_ctl ignored during its 2 cycles, then → IDLE.
- Counters: exactly one of the three counters increments per frame reaching DATA. They wrap at 2^32.

## Timing
- Byte emission:
  - high nibble of byte n (n≥7) sampled at edge k → rx_valid with byte n-6 during cycle k+1;
  - in steady state, beats occur every other cycle.
- End of frame: rgmii_rx_ctl=0 sampled at edge t → beat L-5 in cycle t+1, beat L-4 with rx_last/rx_err/rx_status in cycle t+2.
- rx_err, rx_status: 0 whenever rx_last=0.
- Counters: visible the cycle after the rx_last beat, or after the drop decision edge.
- Reset mid-frame: outputs return to 0 immediately and state → IDLE. The remainder of an in-progress frame is treated as entry to DROP and is not counted.

## Test plan
- Good frame: mac_addr=0x123456789ABC, bcast_en=1; 60-byte broadcast frame plus correct FCS, after 7×0x55 and 0xD5 → exactly 60 beats equal to bytes 0..59, rx_last on beat 60, rx_status=0, frame_ok_count=1.
- CRC error: same frame with the FCS last byte XOR 0x01 → 60 beats, rx_status=4'b0001, frame_err_count=1.
- Address filter:
  - unicast destination 02:00:00:00:00:01, promisc_en=0 → zero beats, drop_count=1;
  - repeat with promisc_en=1 → 60 beats, frame_ok_count increments.
- Runt and alignment:
  - 40-byte frame with valid FCS → 36 beats, rx_status=4'b0010;
  - 64-byte frame ending with one extra nibble → rx_status[3]=1.
- Oversize: 1530-byte frame → rx_last/rx_err on the cycle after byte 1519 completes, too_long=1, no further beats, frame_err_count+1.
- Preamble and reset:
  - 0x55 then nibble 0x3 → drop_count+1, no beats;
  - rst_n pulsed low mid-payload → outputs 0, next good frame received normally, counters 0 before it.
